// File: rtl/ibex_fp_pkg.sv
// Shared FP operation encoding used by the issue/writeback controller
// and the FPU it drives.
package ibex_fp_pkg;

  typedef enum logic [3:0] {
    FPU_NOP    = 4'd0,
    FPU_ADD    = 4'd1,
    FPU_SUB    = 4'd2,
    FPU_MUL    = 4'd3,
    FPU_DIV    = 4'd4,
    FPU_SQRT   = 4'd5,
    FPU_MADD   = 4'd6,
    FPU_MIN    = 4'd7,
    FPU_MAX    = 4'd8,
    FPU_CVT_WS = 4'd9,
    FPU_CVT_SW = 4'd10,
    FPU_EQ     = 4'd11,
    FPU_LT     = 4'd12,
    FPU_LE     = 4'd13,
    FPU_CLASS  = 4'd14,
    FPU_MV     = 4'd15
  } fpu_op_e;

endpackage

// File: rtl/ibex_fp_issue_wb.sv
// FP issue/writeback controller: owns the FP register file, issues one
// operation at a time to ibex_FPU and commits or forwards its result.
module ibex_fp_issue_wb
  import ibex_fp_pkg::*;
#(
  parameter int NUM_FPR = 32,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fpu_op_e     req_op_i,
  input  logic [2:0]  req_rm_i,
  input  logic [4:0]  req_rs1_addr_i,
  input  logic [4:0]  req_rs2_addr_i,
  input  logic [4:0]  req_rs3_addr_i,
  input  logic [4:0]  req_rd_addr_i,
  output fpu_op_e     fp_op_o,
  output logic [2:0]  fp_rounding_mode_o,
  output logic [31:0] rs1_o,
  output logic [31:0] rs2_o,
  output logic [31:0] rs3_o,
  output logic [4:0]  rd_addr_o,
  input  logic        fp_regfile_write_i,
  input  logic [4:0]  fp_regfile_addr_i,
  input  logic [31:0] fp_regfile_wdata_i,
  input  logic        int_regfile_write_i,
  input  logic [4:0]  int_regfile_addr_i,
  input  logic [31:0] int_regfile_wdata_i,
  output logic        int_wb_valid_o,
  output logic [4:0]  int_wb_addr_o,
  output logic [31:0] int_wb_data_o,
  input  logic        ld_we_i,
  input  logic [4:0]  ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  input  logic [4:0]  dbg_raddr_i,
  output logic [31:0] dbg_rdata_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  fpu_op_e       op_q;
  logic [2:0]    rm_q;
  logic [4:0]    rs1_q, rs2_q, rs3_q, rd_q;
  logic [31:0]   opa_q, opb_q, opc_q;
  logic [31:0]   opa_d, opb_d, opc_d;
  logic [CW-1:0] cnt_q;
  logic          to_q, int_v_q;
  logic [4:0]    int_a_q;
  logic [31:0]   int_d_q;
  logic [31:0]   rf [NUM_FPR];

  logic busy, resp, accept, expire;

  assign busy   = (state_q == ISSUE) || (state_q == WAIT);
  assign resp   = fp_regfile_write_i || int_regfile_write_i;
  assign accept = req_ready_o && req_valid_i;
  assign expire = busy && !resp && (cnt_q == CW'(TIMEOUT - 1));

  // Register-file read with load bypass, used only in ISSUE
  always_comb begin
    opa_d = rf[rs1_q];
    opb_d = rf[rs2_q];
    opc_d = rf[rs3_q];
    if (ld_we_i && ld_addr_i == rs1_q) opa_d = ld_wdata_i;
    if (ld_we_i && ld_addr_i == rs2_q) opb_d = ld_wdata_i;
    if (ld_we_i && ld_addr_i == rs3_q) opc_d = ld_wdata_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i)
          state_d = (req_op_i == FPU_NOP) ? DONE : ISSUE;
      end
      ISSUE, WAIT: begin
        if (resp || expire) state_d = DONE;
        else                state_d = WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= FPU_NOP;
      rm_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      int_v_q <= 1'b0;
      int_a_q <= '0;
      int_d_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op_i;
        rm_q    <= req_rm_i;
        rs1_q   <= req_rs1_addr_i;
        rs2_q   <= req_rs2_addr_i;
        rs3_q   <= req_rs3_addr_i;
        rd_q    <= req_rd_addr_i;
        cnt_q   <= '0;
        to_q    <= 1'b0;
        int_v_q <= 1'b0;
      end
      if (state_q == ISSUE) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
        opc_q <= opc_d;
      end
      if (busy && !resp) cnt_q <= cnt_q + 1'b1;
      if (expire) to_q <= 1'b1;
      if (busy && int_regfile_write_i) begin
        int_v_q <= 1'b1;
        int_a_q <= int_regfile_addr_i;
        int_d_q <= int_regfile_wdata_i;
      end
      if (state_q == DONE) begin
        to_q    <= 1'b0;
        int_v_q <= 1'b0;
      end
    end
  end

  // FPU writeback is ordered after the load so it wins on a collision
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_FPR; i++) rf[i] <= '0;
    end else begin
      if (ld_we_i) rf[ld_addr_i] <= ld_wdata_i;
      if (busy && fp_regfile_write_i)
        rf[fp_regfile_addr_i] <= fp_regfile_wdata_i;
    end
  end

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign dbg_rdata_o = rf[dbg_raddr_i];

  always_comb begin
    fp_op_o            = FPU_NOP;
    fp_rounding_mode_o = '0;
    rd_addr_o          = '0;
    rs1_o              = '0;
    rs2_o              = '0;
    rs3_o              = '0;
    if (busy) begin
      fp_op_o            = op_q;
      fp_rounding_mode_o = rm_q;
      rd_addr_o          = rd_q;
      rs1_o = (state_q == ISSUE) ? opa_d : opa_q;
      rs2_o = (state_q == ISSUE) ? opb_d : opb_q;
      rs3_o = (state_q == ISSUE) ? opc_d : opc_q;
    end
  end

  assign done_o         = (state_q == DONE);
  assign timeout_o      = done_o && to_q;
  assign int_wb_valid_o = done_o && int_v_q;
  assign int_wb_addr_o  = int_wb_valid_o ? int_a_q : '0;
  assign int_wb_data_o  = int_wb_valid_o ? int_d_q : '0;

endmodule

// File: tb/tb_ibex_fp_issue_wb.sv
// Directed self-checking bench for ibex_fp_issue_wb with a short
// timeout so the expiry path is reachable quickly.
module tb_ibex_fp_issue_wb;
  import ibex_fp_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  fpu_op_e     req_op = FPU_NOP;
  logic [2:0]  req_rm = '0;
  logic [4:0]  rs1a = '0, rs2a = '0, rs3a = '0, rda = '0;
  fpu_op_e     fp_op;
  logic [2:0]  fp_rm;
  logic [31:0] rs1, rs2, rs3;
  logic [4:0]  rd_addr;
  logic        fwr = 1'b0;
  logic [4:0]  fadr = '0;
  logic [31:0] fdat = '0;
  logic        iwr = 1'b0;
  logic [4:0]  iadr = '0;
  logic [31:0] idat = '0;
  logic        iwb_v;
  logic [4:0]  iwb_a;
  logic [31:0] iwb_d;
  logic        ld_we = 1'b0;
  logic [4:0]  ld_a = '0;
  logic [31:0] ld_d = '0;
  logic [4:0]  dbg_a = '0;
  logic [31:0] dbg_d;
  logic        done, tmo;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ibex_fp_issue_wb #(.NUM_FPR(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_rm_i(req_rm),
    .req_rs1_addr_i(rs1a), .req_rs2_addr_i(rs2a),
    .req_rs3_addr_i(rs3a), .req_rd_addr_i(rda),
    .fp_op_o(fp_op), .fp_rounding_mode_o(fp_rm),
    .rs1_o(rs1), .rs2_o(rs2), .rs3_o(rs3), .rd_addr_o(rd_addr),
    .fp_regfile_write_i(fwr), .fp_regfile_addr_i(fadr),
    .fp_regfile_wdata_i(fdat),
    .int_regfile_write_i(iwr), .int_regfile_addr_i(iadr),
    .int_regfile_wdata_i(idat),
    .int_wb_valid_o(iwb_v), .int_wb_addr_o(iwb_a),
    .int_wb_data_o(iwb_d),
    .ld_we_i(ld_we), .ld_addr_i(ld_a), .ld_wdata_i(ld_d),
    .dbg_raddr_i(dbg_a), .dbg_rdata_o(dbg_d),
    .done_o(done), .timeout_o(tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    dbg_a = a;
    #1;
    v = dbg_d;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a,
                         input logic [31:0] exp);
    logic [31:0] v;
    rd_reg(a, v);
    check(tag, v, exp);
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    step();
    ld_we = 1'b0;
  endtask

  // Presents a request in IDLE; returns one cycle after acceptance
  task automatic issue(input fpu_op_e op, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3,
                       input logic [4:0] d, input logic [2:0] rm);
    req_valid = 1'b1; req_op = op; req_rm = rm;
    rs1a = a1; rs2a = a2; rs3a = a3; rda = d;
    step();
    req_valid = 1'b0; req_op = FPU_NOP;
  endtask

  initial begin
    int nz;
    logic [31:0] v;

    step();
    check("ready_in_rst", {31'd0, req_ready}, 32'd0);
    check("op_in_rst", {28'd0, fp_op}, {28'd0, FPU_NOP});
    check("done_in_rst", {31'd0, done}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      rd_reg(5'(i), v);
      if (v != 0) nz++;
    end
    check("rst_rf_zero", nz, 0);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    check("nop_after_rst", {28'd0, fp_op}, {28'd0, FPU_NOP});

    // Zero-wait ADD
    load(5'd1, 32'h4023d70a);
    load(5'd2, 32'h41200000);
    issue(FPU_ADD, 5'd2, 5'd1, 5'd0, 5'd3, 3'b001);
    check("add_rs1", rs1, 32'h41200000);
    check("add_rs2", rs2, 32'h4023d70a);
    check("add_op", {28'd0, fp_op}, {28'd0, FPU_ADD});
    check("add_rm", {29'd0, fp_rm}, 32'd1);
    check("add_rd", {27'd0, rd_addr}, 32'd3);
    check("add_busy_rdy", {31'd0, req_ready}, 32'd0);
    fwr = 1'b1; fadr = 5'd3; fdat = 32'h4148F5C2;
    step();
    fwr = 1'b0;
    check("add_done", {31'd0, done}, 32'd1);
    check("add_no_tmo", {31'd0, tmo}, 32'd0);
    check("done_op_nop", {28'd0, fp_op}, {28'd0, FPU_NOP});
    chk_reg("add_f3", 5'd3, 32'h4148F5C2);
    step();
    check("add_idle_done", {31'd0, done}, 32'd0);
    check("add_idle_rdy", {31'd0, req_ready}, 32'd1);

    // Stalled FPU, with a load bypassed into rs2 during ISSUE
    issue(FPU_MUL, 5'd1, 5'd2, 5'd3, 5'd4, 3'b010);
    ld_we = 1'b1; ld_a = 5'd2; ld_d = 32'h3f800000;
    #1;
    check("byp_rs2", rs2, 32'h3f800000);
    step();
    ld_we = 1'b0;
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      if (fp_op != FPU_MUL || rs1 != 32'h4023d70a ||
          rs2 != 32'h3f800000 || rs3 != 32'h4148F5C2 ||
          rd_addr != 5'd4 || req_ready || done) nz++;
      if (i < 4) step();
    end
    check("stall_stable", nz, 0);
    fwr = 1'b1; fadr = 5'd4; fdat = 32'hDEADBEEF;
    step();
    fwr = 1'b0;
    check("stall_done", {31'd0, done}, 32'd1);
    chk_reg("stall_f4", 5'd4, 32'hDEADBEEF);
    step();

    // Timeout with no response
    issue(FPU_DIV, 5'd1, 5'd2, 5'd0, 5'd6, 3'b000);
    nz = 0;
    for (int i = 0; i < TO; i++) begin
      if (done || tmo) nz++;
      step();
    end
    check("tmo_early", nz, 0);
    check("tmo_done", {31'd0, done}, 32'd1);
    check("tmo_pulse", {31'd0, tmo}, 32'd1);
    chk_reg("tmo_f6", 5'd6, 32'd0);
    step();
    check("tmo_clear", {31'd0, tmo}, 32'd0);

    // Response in the final counted cycle beats timeout
    issue(FPU_DIV, 5'd1, 5'd2, 5'd0, 5'd6, 3'b000);
    for (int i = 0; i < TO - 1; i++) step();
    fwr = 1'b1; fadr = 5'd6; fdat = 32'h12345678;
    step();
    fwr = 1'b0;
    check("late_done", {31'd0, done}, 32'd1);
    check("late_no_tmo", {31'd0, tmo}, 32'd0);
    chk_reg("late_f6", 5'd6, 32'h12345678);
    step();

    // Integer result
    issue(FPU_CVT_WS, 5'd1, 5'd0, 5'd0, 5'd5, 3'b000);
    iwr = 1'b1; iadr = 5'd5; idat = 32'd1;
    step();
    iwr = 1'b0;
    check("int_valid", {31'd0, iwb_v}, 32'd1);
    check("int_addr", {27'd0, iwb_a}, 32'd5);
    check("int_data", iwb_d, 32'd1);
    chk_reg("int_f5", 5'd5, 32'd0);
    step();
    check("int_valid_off", {31'd0, iwb_v}, 32'd0);

    // Same-address collision: FPU data wins
    issue(FPU_ADD, 5'd1, 5'd2, 5'd0, 5'd7, 3'b000);
    fwr = 1'b1; fadr = 5'd7; fdat = 32'hAAAA5555;
    ld_we = 1'b1; ld_a = 5'd7; ld_d = 32'h11111111;
    step();
    fwr = 1'b0; ld_we = 1'b0;
    chk_reg("coll_f7", 5'd7, 32'hAAAA5555);
    step();

    // Different addresses: both written
    issue(FPU_ADD, 5'd1, 5'd2, 5'd0, 5'd8, 3'b000);
    fwr = 1'b1; fadr = 5'd8; fdat = 32'h00008888;
    ld_we = 1'b1; ld_a = 5'd9; ld_d = 32'h00009999;
    step();
    fwr = 1'b0; ld_we = 1'b0;
    chk_reg("both_f8", 5'd8, 32'h00008888);
    chk_reg("both_f9", 5'd9, 32'h00009999);
    step();

    // NOP goes straight to DONE
    issue(FPU_NOP, 5'd1, 5'd2, 5'd0, 5'd10, 3'b000);
    check("nop_done", {31'd0, done}, 32'd1);
    check("nop_op", {28'd0, fp_op}, {28'd0, FPU_NOP});
    step();

    // Reset during WAIT
    issue(FPU_ADD, 5'd1, 5'd2, 5'd0, 5'd10, 3'b000);
    step();
    rst = 1'b1;
    fwr = 1'b1; fadr = 5'd10; fdat = 32'hCAFEF00D;
    step();
    fwr = 1'b0;
    check("rstw_done", {31'd0, done}, 32'd0);
    check("rstw_op", {28'd0, fp_op}, {28'd0, FPU_NOP});
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      rd_reg(5'(i), v);
      if (v != 0) nz++;
    end
    check("rstw_rf_zero", nz, 0);
    rst = 1'b0;
    step();
    check("rstw_ready", {31'd0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
